// File: rtl/sevenseg_scan_controller_if.sv
// rtl/sevenseg_scan_controller_if.sv - CPU write bus into the seven-segment scan controller
interface sevenseg_scan_controller_if;
   logic       BUS_WE;
   logic [7:0] ADDR;
   logic [7:0] DATA_IN;

   modport master (output BUS_WE, ADDR, DATA_IN);
   modport slave  (input  BUS_WE, ADDR, DATA_IN);
endinterface

// File: rtl/sevenseg_scan_controller.sv
// rtl/sevenseg_scan_controller.sv - 4-digit common-anode display scanner with frame-synchronous register updates
// Optional leading-zero blanking: define SEVENSEG_LEADING_ZERO_BLANK_EN.
module sevenseg_scan_controller #(
   parameter logic [7:0] BASE_ADDR    = 8'hD0,
   parameter int         REFRESH_DIV  = 100000,
   parameter int         BLANK_CYCLES = 16,
   parameter int         CNT_WIDTH    = 17
) (
   input  logic                        CLK,
   input  logic                        RESET,
   sevenseg_scan_controller_if.slave   bus,
   output logic [3:0]                  SEG_SELECT,
   output logic [7:0]                  HEX_OUT,
   output logic                        FRAME_DONE
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(REFRESH_DIV - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LIT   = CNT_WIDTH'(BLANK_CYCLES);
   localparam logic [7:0]           ADDR_LO   = BASE_ADDR;
   localparam logic [7:0]           ADDR_HI   = BASE_ADDR + 8'd1;
   localparam logic [7:0]           ADDR_CTRL = BASE_ADDR + 8'd2;

   logic [15:0]          shadow_digits;
   logic [7:0]           shadow_ctrl;
   logic [15:0]          active_digits;
   logic [7:0]           active_ctrl;
   logic [CNT_WIDTH-1:0] cnt;
   logic [1:0]           idx;

   logic       slot_end;
   logic       frame_end;
   logic [3:0] cur_digit;
   logic       cur_en;
   logic       cur_dp;
   logic       zero_blank;
   logic       lit;

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      case (n)
         4'h0: seg_decode = 7'h40;
         4'h1: seg_decode = 7'h79;
         4'h2: seg_decode = 7'h24;
         4'h3: seg_decode = 7'h30;
         4'h4: seg_decode = 7'h19;
         4'h5: seg_decode = 7'h12;
         4'h6: seg_decode = 7'h02;
         4'h7: seg_decode = 7'h78;
         4'h8: seg_decode = 7'h00;
         4'h9: seg_decode = 7'h10;
         4'hA: seg_decode = 7'h08;
         4'hB: seg_decode = 7'h03;
         4'hC: seg_decode = 7'h46;
         4'hD: seg_decode = 7'h21;
         4'hE: seg_decode = 7'h06;
         4'hF: seg_decode = 7'h0E;
      endcase
   endfunction

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (idx == 2'd3);
   assign cur_digit = active_digits[{idx, 2'b00} +: 4];
   assign cur_en    = active_ctrl[idx];
   assign cur_dp    = active_ctrl[{1'b1, idx}];

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it and every higher digit hold 0; digit 0 always shows.
   logic [3:0] lead_zero;
   assign lead_zero[3] = (active_digits[15:12] == 4'h0);
   assign lead_zero[2] = lead_zero[3] && (active_digits[11:8] == 4'h0);
   assign lead_zero[1] = lead_zero[2] && (active_digits[7:4] == 4'h0);
   assign lead_zero[0] = 1'b0;
   assign zero_blank   = lead_zero[idx];
`else
   assign zero_blank   = 1'b0;
`endif

   assign lit = (cnt >= CNT_LIT) && cur_en && !zero_blank;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         shadow_digits <= '0;
         shadow_ctrl   <= 8'h0F;
         active_digits <= '0;
         active_ctrl   <= 8'h0F;
         cnt           <= '0;
         idx           <= '0;
         FRAME_DONE    <= 1'b0;
         SEG_SELECT    <= 4'hF;
         HEX_OUT       <= 8'hFF;
      end else begin
         cnt <= slot_end ? '0 : cnt + 1'b1;
         if (slot_end)
            idx <= idx + 2'd1;

         if (bus.BUS_WE) begin
            case (bus.ADDR)
               ADDR_LO:   shadow_digits[7:0]  <= bus.DATA_IN;
               ADDR_HI:   shadow_digits[15:8] <= bus.DATA_IN;
               ADDR_CTRL: shadow_ctrl         <= bus.DATA_IN;
               default:   ;
            endcase
         end

         // Non-blocking copy picks up the pre-write shadow when a write hits the boundary cycle.
         if (frame_end) begin
            active_digits <= shadow_digits;
            active_ctrl   <= shadow_ctrl;
         end
         FRAME_DONE <= frame_end;

         if (lit) begin
            SEG_SELECT <= ~(4'b0001 << idx);
            HEX_OUT    <= {~cur_dp, seg_decode(cur_digit)};
         end else begin
            SEG_SELECT <= 4'hF;
            HEX_OUT    <= 8'hFF;
         end
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_controller.sv
// tb/tb_sevenseg_scan_controller.sv - directed self-checking bench for sevenseg_scan_controller
module tb_sevenseg_scan_controller;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [3:0] SEG_SELECT;
   logic [7:0] HEX_OUT;
   logic       FRAME_DONE;

   int k      = 0;
   int passed = 0;
   int total  = 0;

   logic [7:0] f1_sel [4] = '{8'h0E, 8'h0D, 8'h0B, 8'h07};
   logic [7:0] f1_hex [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};

   sevenseg_scan_controller_if bus_if ();

   sevenseg_scan_controller #(
      .BASE_ADDR    (8'hD0),
      .REFRESH_DIV  (8),
      .BLANK_CYCLES (2),
      .CNT_WIDTH    (3)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .bus        (bus_if),
      .SEG_SELECT (SEG_SELECT),
      .HEX_OUT    (HEX_OUT),
      .FRAME_DONE (FRAME_DONE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s at k=%0d: observed %h expected %h", tag, k, obs, exp);
   endtask

   // Edge count k since reset release; FRAME_DONE must be high exactly after every 32nd edge.
   task automatic step();
      @(posedge CLK);
      #1;
      k++;
      chk("frame_done", {7'd0, FRAME_DONE}, {7'd0, (k % 32) == 0});
   endtask

   task automatic run_to(input int target);
      while (k < target) step();
   endtask

   task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
      bus_if.BUS_WE  = 1'b1;
      bus_if.ADDR    = addr;
      bus_if.DATA_IN = data;
      step();
      bus_if.BUS_WE  = 1'b0;
   endtask

   initial begin
      bus_if.BUS_WE  = 1'b0;
      bus_if.ADDR    = 8'h00;
      bus_if.DATA_IN = 8'h00;

      // Power-on reset
      #12;
      chk("por_sel", {4'd0, SEG_SELECT}, 8'h0F);
      chk("por_hex", HEX_OUT, 8'hFF);
      chk("por_fd", {7'd0, FRAME_DONE}, 8'h00);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      k = 0;
      run_to(5);
      chk("pre_rst_sel", {4'd0, SEG_SELECT}, 8'h0E);
      chk("pre_rst_hex", HEX_OUT, 8'hC0);

      // Mid-slot asynchronous reset
      RESET = 1'b1;
      #2;
      chk("async_rst_sel", {4'd0, SEG_SELECT}, 8'h0F);
      chk("async_rst_hex", HEX_OUT, 8'hFF);
      chk("async_rst_fd", {7'd0, FRAME_DONE}, 8'h00);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      k = 0;
      step();
      chk("rel_k1_sel", {4'd0, SEG_SELECT}, 8'h0F);
      step();
      chk("rel_k2_hex", HEX_OUT, 8'hFF);
      step();
      chk("rel_k3_sel", {4'd0, SEG_SELECT}, 8'h0E);
      chk("rel_k3_hex", HEX_OUT, 8'hC0);

      // Hex pattern: shadow only until the boundary at edge 32
      bus_write(8'hD0, 8'h21);
      bus_write(8'hD1, 8'h43);
      run_to(11);
      chk("f0_old_sel", {4'd0, SEG_SELECT}, 8'h0D);
      chk("f0_old_hex", HEX_OUT, 8'hC0);
      for (int d = 0; d < 4; d++) begin
         for (int c = 1; c <= 8; c++) begin
            run_to(32 + 8 * d + c);
            if (c < 3) begin
               chk("f1_blank_sel", {4'd0, SEG_SELECT}, 8'h0F);
               chk("f1_blank_hex", HEX_OUT, 8'hFF);
            end else begin
               chk("f1_sel", {4'd0, SEG_SELECT}, f1_sel[d]);
               chk("f1_hex", HEX_OUT, f1_hex[d]);
            end
         end
      end

      // Tearing guard: mid-frame write must not show until edge 96
      run_to(73);
      bus_write(8'hD0, 8'hFF);
      run_to(75);
      chk("tear_old_sel", {4'd0, SEG_SELECT}, 8'h0D);
      chk("tear_old_hex", HEX_OUT, 8'hA4);
      run_to(99);
      chk("tear_new0_sel", {4'd0, SEG_SELECT}, 8'h0E);
      chk("tear_new0_hex", HEX_OUT, 8'h8E);
      run_to(107);
      chk("tear_new1_hex", HEX_OUT, 8'h8E);
      run_to(115);
      chk("tear_d2_hex", HEX_OUT, 8'hB0);

      // Boundary collision: control write captured on the boundary edge 128
      run_to(127);
      bus_write(8'hD2, 8'h05);
      run_to(139);
      chk("coll_d1_sel", {4'd0, SEG_SELECT}, 8'h0D);
      chk("coll_d1_hex", HEX_OUT, 8'h8E);
      run_to(155);
      chk("coll_d3_sel", {4'd0, SEG_SELECT}, 8'h07);
      chk("coll_d3_hex", HEX_OUT, 8'h99);
      run_to(163);
      chk("after_d0_hex", HEX_OUT, 8'h8E);
      run_to(171);
      chk("after_d1_sel", {4'd0, SEG_SELECT}, 8'h0F);
      chk("after_d1_hex", HEX_OUT, 8'hFF);
      run_to(179);
      chk("after_d2_sel", {4'd0, SEG_SELECT}, 8'h0B);
      chk("after_d2_hex", HEX_OUT, 8'hB0);
      run_to(187);
      chk("after_d3_sel", {4'd0, SEG_SELECT}, 8'h0F);

      // DP on digit 0, only digits 0/1 enabled
      run_to(188);
      bus_write(8'hD2, 8'h13);
      bus_write(8'hD0, 8'h00);
      bus_write(8'hD1, 8'h00);
      run_to(195);
      chk("dp_d0_sel", {4'd0, SEG_SELECT}, 8'h0E);
      chk("dp_d0_hex", HEX_OUT, 8'h40);
      run_to(203);
      chk("dp_d1_sel", {4'd0, SEG_SELECT}, 8'h0D);
      chk("dp_d1_hex", HEX_OUT, 8'hC0);
      for (int t = 209; t <= 219; t++) begin
         run_to(t);
         chk("dis_sel", {4'd0, SEG_SELECT}, 8'h0F);
         chk("dis_hex", HEX_OUT, 8'hFF);
      end

      // Digits 0x0005, all enabled; write to an unmapped address is ignored
      bus_write(8'hD2, 8'h0F);
      bus_write(8'hD0, 8'h05);
      bus_write(8'hD1, 8'h00);
      bus_write(8'hD3, 8'h00);
      run_to(227);
      chk("lz_d0_sel", {4'd0, SEG_SELECT}, 8'h0E);
      chk("lz_d0_hex", HEX_OUT, 8'h92);
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
      run_to(235);
      chk("lz_d1_sel", {4'd0, SEG_SELECT}, 8'h0F);
      chk("lz_d1_hex", HEX_OUT, 8'hFF);
      run_to(243);
      chk("lz_d2_hex", HEX_OUT, 8'hFF);
      run_to(251);
      chk("lz_d3_sel", {4'd0, SEG_SELECT}, 8'h0F);
`else
      run_to(235);
      chk("lz_d1_sel", {4'd0, SEG_SELECT}, 8'h0D);
      chk("lz_d1_hex", HEX_OUT, 8'hC0);
      run_to(243);
      chk("lz_d2_hex", HEX_OUT, 8'hC0);
      run_to(251);
      chk("lz_d3_sel", {4'd0, SEG_SELECT}, 8'h07);
      chk("lz_d3_hex", HEX_OUT, 8'hC0);
`endif
      run_to(257);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
